// File: rtl/conv_il_pkg.sv
// Shared constants and elaboration-time helpers for the
// convolutional interleaver/deinterleaver core.
package conv_il_pkg;

    localparam int CIL_WIDTH      = 8;
    localparam int CIL_BRANCHES   = 12;
    localparam int CIL_UNIT_DEPTH = 17;

    // Never returns less than 1 so a pointer always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic int branch_depth(
        input int b,
        input int n,
        input int m,
        input bit deint
    );
        return deint ? (n - 1 - b) * m : b * m;
    endfunction

endpackage

// File: rtl/conv_branch_delay.sv
// One commutator branch: a DEPTH-stage enabled shift register,
// or a plain wire when the branch has no delay.
module conv_branch_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused;
        assign unused = &{1'b0, clk, reset, en};
        assign dout   = din;
    end else begin : g_sr
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else if (en) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        // Oldest stage is presented before the shift that replaces it.
        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/conv_interleaver.sv
// Forney convolutional interleaver/deinterleaver with rotating
// commutator, per-symbol valid qualification and sync alignment.
module conv_interleaver
    import conv_il_pkg::*;
#(
    parameter  int WIDTH        = CIL_WIDTH,
    parameter  int BRANCHES     = CIL_BRANCHES,
    parameter  int UNIT_DEPTH   = CIL_UNIT_DEPTH,
    parameter  int DEINTERLEAVE = 0,
    localparam int PW           = clog2(BRANCHES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             sync_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic [PW-1:0]    branch_idx
);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    ptr_nxt;
    logic [WIDTH-1:0] br_out [BRANCHES];

    // Sync forces branch 0 without flushing or shifting skipped branches.
    always_comb begin
        sel     = sync_in ? '0 : ptr;
        ptr_nxt = '0;
        if (sel != PW'(BRANCHES - 1)) ptr_nxt = sel + PW'(1);
    end

    for (genvar b = 0; b < BRANCHES; b++) begin : g_br
        localparam int D = branch_depth(
            b, BRANCHES, UNIT_DEPTH, DEINTERLEAVE != 0);

        conv_branch_delay #(
            .WIDTH (WIDTH),
            .DEPTH (D)
        ) u_br (
            .clk   (clk),
            .reset (reset),
            .en    (in_valid && (sel == PW'(b))),
            .din   (data_in),
            .dout  (br_out[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            branch_idx <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ptr        <= ptr_nxt;
                data_out   <= br_out[sel];
                branch_idx <= sel;
            end
        end
    end

endmodule

// File: tb/tb_conv_interleaver.sv
// Scoreboard bench for conv_interleaver: queue-based reference
// model plus an interleaver->deinterleaver cascade check.
module tb_conv_interleaver;

    localparam int W       = 8;
    localparam int N       = 12;
    localparam int M       = 17;
    localparam int PW      = 4;
    localparam int CASCADE = (N - 1) * M * N;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [PW-1:0] br;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          sync_in = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          out_valid;
    logic [PW-1:0] branch_idx;
    logic [W-1:0]  d_data;
    logic          d_valid;
    logic [PW-1:0] d_idx;

    int errors = 0;
    int checks = 0;

    exp_t         expq [$];
    logic [W-1:0] hist [N][$];
    int           mptr = 0;
    logic [W-1:0] exp_last = '0;
    logic         exp_v = 1'b0;
    logic         mon_en = 1'b0;

    logic         rec_on = 1'b0;
    int           rec_sel = 0;
    logic [W-1:0] rec0 [$];
    logic [W-1:0] rec1 [$];
    logic [W-1:0] reca [$];

    logic         cas_on = 1'b0;
    logic [W-1:0] cas_in [$];
    int           cas_k = 0;

    always #5 clk = ~clk;

    conv_interleaver #(
        .WIDTH(W), .BRANCHES(N), .UNIT_DEPTH(M), .DEINTERLEAVE(0)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .sync_in    (sync_in),
        .data_in    (data_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .branch_idx (branch_idx)
    );

    conv_interleaver #(
        .WIDTH(W), .BRANCHES(N), .UNIT_DEPTH(M), .DEINTERLEAVE(1)
    ) u_deint (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (out_valid),
        .sync_in    (branch_idx == '0),
        .data_in    (data_out),
        .data_out   (d_data),
        .out_valid  (d_valid),
        .branch_idx (d_idx)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each branch is a FIFO of depth b*M: a symbol leaves when the
    // branch has seen that many newer symbols; empty slots read zero.
    task automatic model_step(input logic s, input logic [W-1:0] d);
        exp_t e;
        int   sel;
        int   dep;
        sel  = s ? 0 : mptr;
        mptr = (sel + 1) % N;
        dep  = sel * M;
        e.br = PW'(sel);
        if (dep == 0) begin
            e.data = d;
        end else begin
            e.data = (hist[sel].size() == dep) ? hist[sel].pop_front() : '0;
            hist[sel].push_back(d);
        end
        expq.push_back(e);
    endtask

    task automatic send(input logic v, input logic s, input logic [W-1:0] d);
        in_valid = v;
        sync_in  = s;
        data_in  = d;
        if (v) begin
            model_step(s, d);
            if (cas_on) cas_in.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        reset    = 1'b1;
        in_valid = v;
        sync_in  = 1'b0;
        data_in  = 8'hA5;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int b = 0; b < N; b++) hist[b].delete();
        mptr     = 0;
        exp_last = '0;
        expq.delete();
        cas_in.delete();
        cas_k    = 0;
    endtask

    always @(posedge clk) exp_v <= reset ? 1'b0 : in_valid;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(exp_v));
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none",
                             data_out);
                end else begin
                    e = expq.pop_front();
                    check("data_out", 32'(data_out), 32'(e.data));
                    check("branch_idx", 32'(branch_idx), 32'(e.br));
                    exp_last = e.data;
                end
                if (rec_on) begin
                    if (rec_sel == 0) rec0.push_back(data_out);
                    else if (rec_sel == 1) rec1.push_back(data_out);
                    else reca.push_back(data_out);
                end
            end else begin
                check("data_hold", 32'(data_out), 32'(exp_last));
            end
        end
    end

    // Interleave then deinterleave must be a pure fixed delay.
    always @(negedge clk) begin
        logic [W-1:0] ce;
        if (cas_on && d_valid) begin
            ce = (cas_k >= CASCADE) ? cas_in[cas_k-CASCADE] : '0;
            check("cascade_data", 32'(d_data), 32'(ce));
            check("cascade_branch", 32'(d_idx), 32'(cas_k % N));
            cas_k++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] arr [500];
        logic         did_sync;
        int           sent;
        logic         v;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_branch_idx", 32'(branch_idx), 32'h0);
        mon_en = 1'b1;

        // Counting stream, gap-free.
        rec_on  = 1'b1;
        rec_sel = 2;
        for (int j = 0; j < 2300; j++) send(1'b1, j == 0, 8'(j));
        send(1'b0, 1'b0, 8'h00);
        send(1'b0, 1'b0, 8'h00);
        rec_on = 1'b0;
        check("count_len", 32'(reca.size()), 32'd2300);
        if (reca.size() >= 2300) begin
            check("idx0", 32'(reca[0]), 32'h00);
            check("idx12_pass", 32'(reca[12]), 32'h0C);
            check("idx13_unfilled", 32'(reca[13]), 32'h00);
            check("idx205", 32'(reca[205]), 32'h01);
            check("idx217", 32'(reca[217]), 32'h0D);
            check("idx2243_unfilled", 32'(reca[2243]), 32'h00);
            check("idx2255", 32'(reca[2255]), 32'h0B);
        end

        // Random bytes with 50% idle cycles, fed through the cascade.
        do_reset(1'b1);
        cas_on = 1'b1;
        sent   = 0;
        while (sent < 3000) begin
            v = 1'($urandom % 2);
            send(v, v && (sent == 0), 8'($urandom));
            if (v) sent++;
        end
        repeat (3) send(1'b0, 1'b0, 8'h00);
        cas_on = 1'b0;
        check("cascade_count", 32'(cas_k), 32'd3000);

        // Sync while the commutator sits on branch 5.
        do_reset(1'b0);
        did_sync = 1'b0;
        for (int j = 0; j < 400; j++) begin
            if (j >= 100 && mptr == 5 && !did_sync) begin
                did_sync = 1'b1;
                send(1'b1, 1'b1, 8'($urandom));
            end else begin
                send(1'b1, j == 0, 8'($urandom));
            end
        end
        send(1'b0, 1'b0, 8'h00);

        // Mid-stream reset followed by an exact replay.
        for (int i = 0; i < 500; i++) arr[i] = 8'($urandom);
        do_reset(1'b0);
        rec_on  = 1'b1;
        rec_sel = 0;
        for (int i = 0; i < 500; i++) send(1'b1, i == 0, arr[i]);
        do_reset(1'b1);
        rec_sel = 1;
        check("midreset_data_out", 32'(data_out), 32'h0);
        check("midreset_out_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 500; i++) send(1'b1, i == 0, arr[i]);
        send(1'b0, 1'b0, 8'h00);
        send(1'b0, 1'b0, 8'h00);
        rec_on = 1'b0;
        check("replay_len", 32'(rec1.size()), 32'(rec0.size()));
        check("first_len", 32'(rec0.size()), 32'd500);
        if (rec0.size() == 500 && rec1.size() == 500) begin
            for (int i = 0; i < 500; i++)
                check("replay_data", 32'(rec1[i]), 32'(rec0[i]));
        end

        repeat (2) send(1'b0, 1'b0, 8'h00);
        check("queue_drained", 32'(expq.size()), 32'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
